// File: rtl/tpu_tile_sequencer.sv
// Tiled matmul sequencer: walks every ARRAY_DIM x ARRAY_DIM output tile of
// C = A(MxK) * B(KxN). For each tile it streams A/B read indices, strobes the
// PE array, waits for the array to drain, and writes one C word per tile row.
// Every output is a register, so each output reflects the state currently held.
module tpu_tile_sequencer #(
  parameter int ARRAY_DIM    = 4,
  parameter int DRAIN_CYCLES = 7,
  parameter int IDX_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       M,
  input  logic [7:0]       K,
  input  logic [7:0]       N,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] A_index,
  output logic [IDX_W-1:0] B_index,
  output logic             pe_clear,
  output logic             pe_valid,
  output logic [1:0]       out_row,
  output logic [IDX_W-1:0] C_index,
  output logic             C_wr_en
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [IDX_W-1:0] STEP       = IDX_W'(ARRAY_DIM);
  localparam logic [7:0]       DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
  localparam logic [7:0]       ROW_LAST   = 8'(ARRAY_DIM - 1);

  state_t state, state_d;

  // Latched job dimensions; a zero-sized job skips all tile work.
  logic [7:0] m_dim, k_dim, n_dim;
  logic [7:0] m_dim_d, k_dim_d, n_dim_d;
  logic       zero_job, zero_job_d;

  // Shared phase counter: k in LOAD, drain count in DRAIN, row r in WRITE.
  logic [7:0] cnt, cnt_d;

  // Tile position kept as running sums so no multipliers are needed:
  // m_row = mt*ARRAY_DIM, n_col = nt*ARRAY_DIM, a_base = mt*K,
  // b_base = nt*K, c_col = nt*M.
  logic [IDX_W-1:0] m_row, n_col, a_base, b_base, c_col;
  logic [IDX_W-1:0] m_row_d, n_col_d, a_base_d, b_base_d, c_col_d;

  // Next values of the registered outputs.
  logic             busy_d, done_d, pe_clear_d, pe_valid_d, c_wr_en_d;
  logic [IDX_W-1:0] a_index_d, b_index_d, c_index_d;
  logic [1:0]       out_row_d;
  logic [IDX_W-1:0] next_row;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state, counter, tile-position and output-value decode.
  always_comb begin
    state_d    = state;
    m_dim_d    = m_dim;
    k_dim_d    = k_dim;
    n_dim_d    = n_dim;
    zero_job_d = zero_job;
    cnt_d      = cnt;
    m_row_d    = m_row;
    n_col_d    = n_col;
    a_base_d   = a_base;
    b_base_d   = b_base;
    c_col_d    = c_col;
    a_index_d  = A_index;
    b_index_d  = B_index;
    c_index_d  = C_index;
    out_row_d  = out_row;
    pe_clear_d = 1'b0;
    c_wr_en_d  = 1'b0;
    next_row   = m_row + IDX_W'(cnt) + IDX_W'(1);

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          m_dim_d    = M;
          k_dim_d    = K;
          n_dim_d    = N;
          zero_job_d = (M == 8'd0) || (K == 8'd0) || (N == 8'd0);
          m_row_d    = '0;
          n_col_d    = '0;
          a_base_d   = '0;
          b_base_d   = '0;
          c_col_d    = '0;
          cnt_d      = 8'd0;
          state_d    = S_CLEAR;
          // An empty job passes through CLEAR without touching the array.
          pe_clear_d = !((M == 8'd0) || (K == 8'd0) || (N == 8'd0));
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (zero_job) begin
          state_d = S_DONE;
        end else begin
          state_d   = S_LOAD;
          cnt_d     = 8'd0;
          a_index_d = a_base;
          b_index_d = b_base;
        end
      end
      S_LOAD: begin
        if (cnt == k_dim - 8'd1) begin
          state_d = S_FLUSH;
        end else begin
          cnt_d     = cnt + 8'd1;
          a_index_d = A_index + IDX_W'(1);
          b_index_d = B_index + IDX_W'(1);
        end
      end
      S_FLUSH: begin
        state_d = S_DRAIN;
        cnt_d   = 8'd0;
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_d   = S_WRITE;
          cnt_d     = 8'd0;
          out_row_d = 2'd0;
          c_index_d = c_col + m_row;
          c_wr_en_d = (m_row < IDX_W'(m_dim));
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      S_WRITE: begin
        if (cnt == ROW_LAST) begin
          cnt_d = 8'd0;
          if (n_col + STEP < IDX_W'(n_dim)) begin
            // Next column tile in the same tile row.
            n_col_d    = n_col + STEP;
            b_base_d   = b_base + IDX_W'(k_dim);
            c_col_d    = c_col + IDX_W'(m_dim);
            state_d    = S_CLEAR;
            pe_clear_d = 1'b1;
          end else if (m_row + STEP < IDX_W'(m_dim)) begin
            // Wrap to the first column tile of the next tile row.
            n_col_d    = '0;
            b_base_d   = '0;
            c_col_d    = '0;
            m_row_d    = m_row + STEP;
            a_base_d   = a_base + IDX_W'(k_dim);
            state_d    = S_CLEAR;
            pe_clear_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d     = cnt + 8'd1;
          out_row_d = 2'(cnt + 8'd1);
          c_index_d = C_index + IDX_W'(1);
          c_wr_en_d = (next_row < IDX_W'(m_dim));
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    pe_valid_d = (state == S_LOAD);
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dim    <= 8'd0;
      k_dim    <= 8'd0;
      n_dim    <= 8'd0;
      zero_job <= 1'b0;
      cnt      <= 8'd0;
      m_row    <= '0;
      n_col    <= '0;
      a_base   <= '0;
      b_base   <= '0;
      c_col    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      A_index  <= '0;
      B_index  <= '0;
      pe_clear <= 1'b0;
      pe_valid <= 1'b0;
      out_row  <= 2'd0;
      C_index  <= '0;
      C_wr_en  <= 1'b0;
    end else begin
      m_dim    <= m_dim_d;
      k_dim    <= k_dim_d;
      n_dim    <= n_dim_d;
      zero_job <= zero_job_d;
      cnt      <= cnt_d;
      m_row    <= m_row_d;
      n_col    <= n_col_d;
      a_base   <= a_base_d;
      b_base   <= b_base_d;
      c_col    <= c_col_d;
      busy     <= busy_d;
      done     <= done_d;
      A_index  <= a_index_d;
      B_index  <= b_index_d;
      pe_clear <= pe_clear_d;
      pe_valid <= pe_valid_d;
      out_row  <= out_row_d;
      C_index  <= c_index_d;
      C_wr_en  <= c_wr_en_d;
    end
  end

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Bench for tpu_tile_sequencer: directed jobs plus random-dimension jobs, each
// checked cycle by cycle against a timeline computed from the job dimensions.
module tb_tpu_tile_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  M, K, N;
  logic        busy, done, pe_clear, pe_valid, C_wr_en;
  logic [15:0] A_index, B_index, C_index;
  logic [1:0]  out_row;

  int total = 0;
  int bad   = 0;

  tpu_tile_sequencer #(.ARRAY_DIM(4), .DRAIN_CYCLES(7), .IDX_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .M(M), .K(K), .N(N),
    .busy(busy), .done(done),
    .A_index(A_index), .B_index(B_index),
    .pe_clear(pe_clear), .pe_valid(pe_valid),
    .out_row(out_row), .C_index(C_index), .C_wr_en(C_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".pe_clear"}, 32'(pe_clear), 32'd0);
    chk({tag, ".pe_valid"}, 32'(pe_valid), 32'd0);
    chk({tag, ".C_wr_en"}, 32'(C_wr_en), 32'd0);
    chk({tag, ".A_index"}, 32'(A_index), 32'd0);
    chk({tag, ".B_index"}, 32'(B_index), 32'd0);
    chk({tag, ".C_index"}, 32'(C_index), 32'd0);
    chk({tag, ".out_row"}, 32'(out_row), 32'd0);
  endtask

  // Run one job and compare every cycle against the tile timeline.
  // Cycle c=1 is the first cycle after the accepting edge. Each tile spans
  // L = K+13 cycles: clear at p=0, loads at p=1..K, valid at p=2..K+1,
  // writes at p=K+9..K+12. Optionally pulse in_valid with other dims at
  // cycle 'glitch' to confirm it is ignored.
  task automatic run_job(input int m, input int k, input int n, input int glitch);
    int mtiles, ntiles, len, last, wr_count;
    bit zero;
    zero   = (m == 0) || (k == 0) || (n == 0);
    mtiles = (m + 3) / 4;
    ntiles = (n + 3) / 4;
    len    = k + 13;
    last   = zero ? 2 : (mtiles * ntiles * len + 1);
    wr_count = 0;

    @(negedge clk);
    in_valid = 1'b1;
    M = 8'(m); K = 8'(k); N = 8'(n);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 1; c <= last + 1; c++) begin
      bit e_clear, e_valid, e_wr, e_load, e_write;
      int p, t, mt, nt, r, row;
      e_clear = 0; e_valid = 0; e_wr = 0; e_load = 0; e_write = 0;
      p = 0; t = 0; mt = 0; nt = 0; r = 0; row = 0;
      if (!zero && c < last) begin
        p  = (c - 1) % len;
        t  = (c - 1) / len;
        mt = t / ntiles;
        nt = t % ntiles;
        e_clear = (p == 0);
        e_load  = (p >= 1) && (p <= k);
        e_valid = (p >= 2) && (p <= k + 1);
        e_write = (p >= k + 9) && (p <= k + 12);
        if (e_write) begin
          r    = p - (k + 9);
          row  = mt * 4 + r;
          e_wr = (row < m);
        end
      end
      chk("busy", 32'(busy), 32'(c <= last));
      chk("done", 32'(done), 32'(c == last));
      chk("pe_clear", 32'(pe_clear), 32'(e_clear));
      chk("pe_valid", 32'(pe_valid), 32'(e_valid));
      chk("C_wr_en", 32'(C_wr_en), 32'(e_wr));
      if (e_load) begin
        chk("A_index", 32'(A_index), 32'(mt * k + p - 1));
        chk("B_index", 32'(B_index), 32'(nt * k + p - 1));
      end
      if (e_write) begin
        chk("out_row", 32'(out_row), 32'(r));
      end
      if (e_wr) begin
        chk("C_index", 32'(C_index), 32'(nt * m + row));
        wr_count++;
      end
      if (c == glitch) begin
        in_valid = 1'b1;
        M = 8'(m + 5); K = 8'(k + 3); N = 8'(n + 2);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    // Each real row of C is written once per column tile.
    chk("write_count", 32'(wr_count), zero ? 32'd0 : 32'(m * ntiles));
  endtask

  initial begin
    in_valid = 1'b0;
    M = 8'd0; K = 8'd0; N = 8'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single 4x4x4 tile; done lands 18 cycles after acceptance.
    run_job(4, 4, 4, 0);
    // Four tiles in mt-outer / nt-inner order.
    run_job(8, 3, 8, 0);
    // Partial tile row: rows 6 and 7 of the second tile row are masked.
    run_job(6, 2, 4, 0);
    // Zero inner dimension: no array activity, done two cycles after acceptance.
    run_job(4, 0, 4, 0);
    run_job(0, 3, 4, 0);
    // in_valid pulsed during LOAD with different dims is ignored.
    run_job(4, 4, 4, 3);

    // Reset in the middle of LOAD clears every output at once.
    @(negedge clk);
    in_valid = 1'b1;
    M = 8'd4; K = 8'd4; N = 8'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midload.A_index", 32'(A_index), 32'd1);
    chk("midload.pe_valid", 32'(pe_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run_job(5, 2, 7, 0);

    // Random dimensions.
    for (int j = 0; j < 6; j++) begin
      int rm, rk, rn, rg;
      rm = int'($urandom_range(1, 10));
      rk = int'($urandom_range(1, 5));
      rn = int'($urandom_range(1, 10));
      rg = int'($urandom_range(0, 8));
      run_job(rm, rk, rn, rg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
